// File: rtl/flash_read_responder.sv
// Avalon-MM pipelined read slave in front of a synchronous 32-bit word memory.
// Commands queue in an in-order FIFO; a wait counter emulates flash access latency.
module flash_read_responder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic [3:0]        byteEnable,
  output logic              waitRequest,
  output logic [31:0]       readData,
  output logic              readDataValid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StWait, StRespond} state_e;

  logic [ADDR_W+3:0] fifo_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop, fifo_empty, fifo_full;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       data_q, data_d;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CntW'(DEPTH));
  // Stall comes from the registered count, so a same-cycle pop cannot release it.
  assign waitRequest = reset | fifo_full;
  assign push        = read & ~waitRequest;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {address, byteEnable};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle, StRespond: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          {addr_d, be_d} = fifo_mem[rd_ptr_q];
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        for (int i = 0; i < 4; i++) begin
          data_d[8*i +: 8] = be_q[i] ? mem_rdata[8*i +: 8] : 8'h00;
        end
        if (WAIT_CYCLES == 0) begin
          state_d = StRespond;
        end else begin
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = StRespond;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign mem_rd        = (state_q == StIssue);
  assign readDataValid = (state_q == StRespond);
  assign readData      = data_q;
  assign mem_addr      = addr_q;
  assign busy          = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench: one instance with WAIT_CYCLES=3 and one with WAIT_CYCLES=0 share stimulus,
// each backed by its own one-cycle-latency memory model.
module tb_flash_read_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] address = '0;
  logic        read = 1'b0;
  logic [3:0]  byteEnable = '0;

  logic        wr3, rdv3, mrd3, busy3;
  logic [31:0] rdata3, mrdata3;
  logic [22:0] maddr3;
  logic        wr0, rdv0, mrd0, busy0;
  logic [31:0] rdata0, mrdata0;
  logic [22:0] maddr0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flash_read_responder #(.DEPTH(4), .WAIT_CYCLES(3), .ADDR_W(23)) dut3 (
    .clk(clk), .reset(reset), .address(address), .read(read), .byteEnable(byteEnable),
    .waitRequest(wr3), .readData(rdata3), .readDataValid(rdv3), .mem_addr(maddr3),
    .mem_rd(mrd3), .mem_rdata(mrdata3), .busy(busy3)
  );

  flash_read_responder #(.DEPTH(4), .WAIT_CYCLES(0), .ADDR_W(23)) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(read), .byteEnable(byteEnable),
    .waitRequest(wr0), .readData(rdata0), .readDataValid(rdv0), .mem_addr(maddr0),
    .mem_rd(mrd0), .mem_rdata(mrdata0), .busy(busy0)
  );

  function automatic logic [31:0] memf(input logic [22:0] a);
    if (a == 23'h10) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(a) * 32'h0101_0101;
  endfunction

  always @(posedge clk) begin
    if (mrd3) mrdata3 <= memf(maddr3);
    if (mrd0) mrdata0 <= memf(maddr0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at the start of cycle 0 with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_waitRequest", 32'(wr3), 32'd1);
    chk("rst_readDataValid", 32'(rdv3), 32'd0);
    chk("rst_mem_rd", 32'(mrd3), 32'd0);
    chk("rst_mem_addr", 32'(maddr3), 32'd0);
    chk("rst_readData", rdata3, 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic single(input logic [22:0] a, input logic [3:0] be, input logic [31:0] exp);
    do_reset();
    read = 1'b1;
    address = a;
    byteEnable = be;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("single_accept", 32'(wr3), 32'd0);
      if (c == 0 || c == 11) chk("single_busy_idle", 32'(busy3), 32'd0);
      if (c == 1) chk("single_busy", 32'(busy3), 32'd1);
      chk("single_mem_rd", 32'(mrd3), 32'(c == 2));
      if (c == 2) chk("single_mem_addr", 32'(maddr3), 32'(a));
      chk("single_rdv_w3", 32'(rdv3), 32'(c == 7));
      chk("single_rdv_w0", 32'(rdv0), 32'(c == 4));
      if (c == 7 || c == 11) chk("single_data_w3", rdata3, exp);
      if (c == 4) chk("single_data_w0", rdata0, exp);
      @(posedge clk);
      #1;
      read = 1'b0;
    end
  endtask

  typedef int arr6_t [6];

  // Command k reads address k with all lanes; start[k] is the first cycle it is offered.
  task automatic run_seq(input string name, input int n, input arr6_t start,
                         input arr6_t exp_acc, input arr6_t exp_rdv, input int ncyc);
    int idx = 0;
    int got = 0;
    do_reset();
    byteEnable = 4'hF;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < n && start[idx] <= c) begin
        read = 1'b1;
        address = 23'(idx);
      end else begin
        read = 1'b0;
      end
      @(negedge clk);
      if (read && !wr3) begin
        chk({name, "_accept_cycle"}, 32'(c), 32'(exp_acc[idx]));
        idx++;
      end
      if (rdv3) begin
        if (got < n) begin
          chk({name, "_rdv_cycle"}, 32'(c), 32'(exp_rdv[got]));
          chk({name, "_rdv_data"}, rdata3, memf(23'(got)));
        end else begin
          chk({name, "_extra_rdv"}, 32'(got), 32'(n - 1));
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    read = 1'b0;
    chk({name, "_accepted"}, 32'(idx), 32'(n));
    chk({name, "_responses"}, 32'(got), 32'(n));
    chk({name, "_busy_end"}, 32'(busy3), 32'd0);
  endtask

  typedef struct {
    logic [22:0] addr;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t  vecs[5];
    arr6_t st, acc, rdv;

    vecs[0] = '{addr: 23'h10, be: 4'b1111, exp: 32'hDEADBEEF};
    vecs[1] = '{addr: 23'h10, be: 4'b0101, exp: 32'h00AD00EF};
    vecs[2] = '{addr: 23'h10, be: 4'b1010, exp: 32'hDE00BE00};
    vecs[3] = '{addr: 23'h03, be: 4'b1100, exp: 32'h1303_0000};
    vecs[4] = '{addr: 23'h10, be: 4'b0000, exp: 32'h0000_0000};

    for (int i = 0; i < 5; i++) begin
      single(vecs[i].addr, vecs[i].be, vecs[i].exp);
    end

    // Back-pressure: read held on addresses 0..5 from cycle 0.
    st  = '{0, 0, 0, 0, 0, 0};
    acc = '{0, 1, 2, 3, 4, 8};
    rdv = '{7, 13, 19, 25, 31, 37};
    run_seq("bp", 6, st, acc, rdv, 45);

    // Push in the RESPOND cycle of command 0 while command 1 is queued.
    st  = '{0, 1, 7, 0, 0, 0};
    acc = '{0, 1, 7, 0, 0, 0};
    rdv = '{7, 13, 19, 0, 0, 0};
    run_seq("pushpop", 3, st, acc, rdv, 26);

    // Reset mid-operation with three commands pending.
    do_reset();
    byteEnable = 4'hF;
    for (int c = 0; c < 5; c++) begin
      read = (c < 4);
      address = 23'(c);
      @(posedge clk);
      #1;
    end
    read  = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_waitRequest", 32'(wr3), 32'd1);
    chk("midrst_busy", 32'(busy3), 32'd0);
    chk("midrst_rdv", 32'(rdv3), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_hold_rdv", 32'(rdv3), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    read = 1'b1;
    address = 23'h10;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("postrst_accept", 32'(wr3), 32'd0);
      chk("postrst_rdv", 32'(rdv3), 32'(c == 7));
      if (c == 7) chk("postrst_data", rdata3, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      read = 1'b0;
    end
    chk("postrst_busy_end", 32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
# flash_read_responder

Avalon-MM pipelined read slave that fronts a synchronous 32-bit word memory (on-chip ROM image of the flash audio samples). It serves the flash controller's read master. It accepts read commands into a small in-order command FIFO and emulates flash access latency with a programmable wait counter. It returns byte-lane-masked data with a single-cycle `readDataValid` pulse.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `WAIT_CYCLES`, 3: extra emulated flash latency in clocks, 0..255.
- `ADDR_W`, 23: word address width.

Ports:
- `clk` input 1: system clock (50 MHz). Single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `address` input ADDR_W: word address of the read command.
- `read` input 1: read command strobe.
- `byteEnable` input 4: byte lanes to return. Disabled lanes read as 8'h00.
- `waitRequest` output 1: command not accepted this cycle.
- `readData` output 32: returned word, held between responses.
- `readDataValid` output 1: `readData` is valid this cycle. One-cycle pulse per accepted command.
- `mem_addr` output ADDR_W: backing-memory word address. Registered.
- `mem_rd` output 1: backing-memory read strobe.
- `mem_rdata` input 32: memory data, valid exactly one clock after the `mem_rd` cycle.
- `busy` output 1: FIFO non-empty or FSM not IDLE.

## Operation
- Accept rule: a command is accepted on a rising edge where `read`=1 and `waitRequest`=0. On acceptance, {`address`, `byteEnable`} is pushed to the FIFO.
- `waitRequest` = `reset` | (FIFO count == DEPTH).
  - It is combinational from the registered count.
  - A pop in the same cycle does not clear a full stall.
- FIFO: in-order. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, CAPTURE, WAIT, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head, load `mem_addr` and the lane mask, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_rd`=1. Go to CAPTURE.
  - CAPTURE: latch `mem_rdata` with disabled lanes zeroed into the data register. Then:
    - If WAIT_CYCLES=0, go to RESPOND.
    - Otherwise load cnt=WAIT_CYCLES and go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt==1, go to RESPOND.
  - RESPOND: `readDataValid`=1 and `readData` is driven from the data register. Then:
    - If the FIFO is non-empty, pop and go directly to ISSUE.
    - Otherwise go to IDLE.
- Output decoding: `mem_rd` and `readDataValid` are pure state decodes. `readData` is updated only in CAPTURE and holds its value otherwise.
- Byte masking: lane i is bits [8i+7:8i]. Output lane = `byteEnable[i]` ? `mem_rdata` lane : 8'h00.
- Counter: 8-bit, never wraps (loaded only in CAPTURE).
- `busy` = (count≠0) | (state≠IDLE).

## Timing
Reset values:
- state IDLE; FIFO empty; cnt 0.
- `readData`=0, `readDataValid`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0.
- `waitRequest`=1 while `reset` is high.

Reset mid-operation:
- All pending and in-flight commands are discarded.
- No `readDataValid` is produced for them.
- The first command after reset release is accepted on the first edge with `reset` low.

Latency:
- Command accepted in cycle 0 with the FSM in IDLE. Then IDLE pops in cycle 1, `mem_rd` is high in cycle 2, CAPTURE is cycle 3, and `readDataValid` is high in cycle 4+WAIT_CYCLES.
- Back-to-back throughput: one response every WAIT_CYCLES+3 cycles.
- Responses are returned in acceptance order.

## Test plan
- **Single read, WAIT_CYCLES=3:** mem[0x000010]=32'hDEADBEEF; read 0x10 with BE=4'b1111 in cycle 0.
  - `mem_rd`=1 with `mem_addr`=0x10 in cycle 2 only.
  - `readDataValid`=1 in cycle 7 only; `readData`=32'hDEADBEEF, held afterward.
- **Lane mask:** same read with BE=4'b0101 → `readData`=32'h00AD00EF.
- **Back-pressure, DEPTH=4, WAIT_CYCLES=3:** `read` held high on addresses 0..5 from cycle 0.
  - Five commands are accepted (cycles 0-4). `waitRequest`=1 in cycles 5-7.
  - The sixth command is accepted in cycle 8.
  - Six `readDataValid` pulses occur at cycles 7, 13, 19, … with data for addresses 0..5 in order.
- **WAIT_CYCLES=0:** single read accepted in cycle 0 → `readDataValid` in cycle 4.
- **Reset mid-operation:** assert `reset` in cycle 5 with 3 commands pending.
  - Immediately: `waitRequest`=1, `busy`=0, and no `readDataValid` thereafter.
  - A new read after release returns after the normal latency with correct data.
- **Simultaneous push/pop:** issue a new command in the same cycle as a RESPOND with a non-empty FIFO. The FIFO count is unchanged, and the FSM goes RESPOND→ISSUE with no IDLE cycle.
